cpu_icache: RTL
===============

// Module: cpu_icache
// PURPOSE
// Direct-mapped, read-only instruction cache between the cpu fetch port and the shared memory bus.
// - cpu presents instr_addr (its p1 pc); the cache returns instr_data plus instr_ack one cycle later (p2).
// - On a miss it refills the whole line with sequential single-word bus reads, then completes the fetch.
// - cpu treats !instr_ack as a pipeline bubble or stall and holds instr_addr stable until the ack.
// PARAMETERS
// LINE_WORDS   4    32-bit words per line; power of 2, >=2
// NUM_LINES    64   number of lines; power of 2
// PORTS
// clock        in   1   system clock, all state updates on rising edge
// reset        in   1   synchronous, active-high
// instr_addr   in   32  fetch byte address; bits[1:0] ignored
// instr_data   out  32  fetched instruction, valid when instr_ack=1
// instr_ack    out  1   instr_data is valid for the address sampled on the previous edge
// flush        in   1   one-cycle pulse: invalidate the whole cache
// mem_request  out  1   bus read request
// mem_address  out  32  bus word address; bits[1:0] are always 0
// mem_rdata    in   32  bus read data, valid when mem_ack=1
// mem_ack      in   1   one-cycle completion of the current request
// BEHAVIOUR
// Address split (defaults):
// - word offset = addr[3:2]
// - index = addr[9:4]
// - tag = addr[31:10]
// - Widths follow from the parameters via $clog2.
// Storage:
// - data array of NUM_LINES*LINE_WORDS x 32, read synchronously
// - tag array of NUM_LINES x tag bits
// - valid array of NUM_LINES x 1, held in flops so it can be cleared in one cycle
// Reset:
// - All valid bits cleared; state=IDLE; fill counter=0.
// - instr_ack=0, instr_data=0, mem_request=0, mem_address=0.
// - Reset during FILL abandons the fill. The line being filled stays invalid.
// States:
// - IDLE: each edge samples instr_addr.
//   - Hit (valid & tag match): instr_ack=1 and instr_data=word on the next cycle (1-cycle latency, back-to-back hits every cycle).
//   - Miss: instr_ack=0 next cycle. Latch miss address and go to FILL with counter=0.
//   - mem_address = line base, mem_request=1.
// - FILL: mem_request held high; mem_address = line base + 4*counter, held stable until mem_ack.
//   - On mem_ack: write mem_rdata into data[index][counter] and increment counter.
//   - mem_address advances on the same edge. Request high with a new address the next cycle is a new transaction.
//   - On the ack of the last word (counter = LINE_WORDS-1): write tag, set valid (unless flush seen), drop mem_request, go to RESUME.
// - RESUME: one cycle re-reads the latched miss address. instr_ack=1 and instr_data=requested word on the next cycle; back to IDLE.
// - instr_ack=0 in every cycle that is not the hit or RESUME response.
// Flush:
// - Clears all valid bits on the edge it is sampled.
// - A lookup in the same cycle as flush is a miss.
// - Flush during FILL: the fill runs to completion on the bus (no aborted bus cycle), but the line is NOT marked valid. RESUME still returns the filled word, then the next fetch misses.
// Simultaneous events:
// - reset has priority over flush and mem_ack.
// - mem_ack while mem_request=0 is ignored.
// - instr_addr changes during FILL/RESUME are ignored; only the latched miss address is served.
// Fill order is always word 0..LINE_WORDS-1 (no critical-word-first). Fill latency is LINE_WORDS bus transactions plus 2 cycles.
// TESTING
// - Cold miss at 0x0000_0100, mem_ack 2 cycles after each request -> requests to 0x100,0x104,0x108,0x10C in order. instr_ack=1 with word 0x100 one cycle after RESUME.
// - After the fill, fetch 0x104,0x108,0x10C on consecutive cycles -> instr_ack=1 every cycle with correct data, mem_request stays 0.
// - Conflict: fill 0x000, then fetch 0x400 (same index) -> refill from 0x400. Then fetch 0x000 -> miss and refill again.
// - flush pulse during the 2nd word of a fill -> 4 bus reads complete, RESUME returns correct data, re-fetch of the same address misses.
// - reset asserted mid-FILL (after word 1 ack) -> next cycle mem_request=0, instr_ack=0, and the fetch of that line misses.
// - mem_ack in the same cycle as the request (zero wait) for every word -> fill takes 4 cycles and the data is still correct.

Source files
------------

// File: rtl/cpu_icache.sv
// Direct-mapped, read-only instruction cache: 1-cycle hits, whole-line refill
// over a single-word request/ack bus on a miss.
module cpu_icache #(
    parameter int LINE_WORDS = 4,
    parameter int NUM_LINES  = 64
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [31:0] instr_addr,
    output logic [31:0] instr_data,
    output logic        instr_ack,
    input  logic        flush,
    output logic        mem_request,
    output logic [31:0] mem_address,
    input  logic [31:0] mem_rdata,
    input  logic        mem_ack,
    output logic [1:0]  dbg_state
);
    localparam int OFF_W    = $clog2(LINE_WORDS);
    localparam int IDX_W    = $clog2(NUM_LINES);
    localparam int LINE_LSB = OFF_W + 2;
    localparam int TAG_W    = 32 - LINE_LSB - IDX_W;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        FILL   = 2'd1,
        RESUME = 2'd2
    } state_t;

    state_t               state;
    logic [TAG_W-1:0]     tag_mem  [NUM_LINES];
    logic [31:0]          data_mem [NUM_LINES*LINE_WORDS];
    logic [NUM_LINES-1:0] valid_q;
    logic [31:2]          miss_addr;
    logic [OFF_W-1:0]     fill_cnt;
    logic [OFF_W-1:0]     fill_next;
    logic                 flush_seen;

    logic [OFF_W-1:0]       req_off, miss_off;
    logic [IDX_W-1:0]       req_idx, miss_idx;
    logic [TAG_W-1:0]       req_tag, miss_tag;
    logic                   lookup_hit;
    logic                   fill_ack;
    logic                   fill_last;
    logic [IDX_W+OFF_W-1:0] rd_ptr;
    logic                   unused_addr_bits;

    assign req_off  = instr_addr[LINE_LSB-1:2];
    assign req_idx  = instr_addr[LINE_LSB+IDX_W-1:LINE_LSB];
    assign req_tag  = instr_addr[31:LINE_LSB+IDX_W];
    assign miss_off = miss_addr[LINE_LSB-1:2];
    assign miss_idx = miss_addr[LINE_LSB+IDX_W-1:LINE_LSB];
    assign miss_tag = miss_addr[31:LINE_LSB+IDX_W];
    assign unused_addr_bits = ^instr_addr[1:0];

    // A flush in the lookup cycle wins over a tag match.
    assign lookup_hit = valid_q[req_idx] && (tag_mem[req_idx] == req_tag) && !flush;
    // Bus handshake: mem_request/mem_address stay stable until the edge where
    // mem_ack is sampled high; that edge completes exactly one word transfer.
    // instr_ack qualifies instr_data for a single cycle.
    assign fill_ack   = (state == FILL) && mem_request && mem_ack;
    assign fill_last  = (fill_cnt == OFF_W'(LINE_WORDS - 1));
    assign fill_next  = fill_cnt + 1'b1;
    assign rd_ptr     = (state == RESUME) ? {miss_idx, miss_off} : {req_idx, req_off};
    assign dbg_state  = state;

    always_ff @(posedge clock) begin
        if (fill_ack && !reset) begin
            data_mem[{miss_idx, fill_cnt}] <= mem_rdata;
            if (fill_last) tag_mem[miss_idx] <= miss_tag;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state       <= IDLE;
            valid_q     <= '0;
            fill_cnt    <= '0;
            flush_seen  <= 1'b0;
            miss_addr   <= '0;
            instr_ack   <= 1'b0;
            instr_data  <= '0;
            mem_request <= 1'b0;
            mem_address <= '0;
        end else begin
            instr_ack <= 1'b0;
            case (state)
                IDLE: begin
                    instr_data <= data_mem[rd_ptr];
                    if (lookup_hit) begin
                        instr_ack <= 1'b1;
                    end else begin
                        miss_addr   <= instr_addr[31:2];
                        fill_cnt    <= '0;
                        flush_seen  <= 1'b0;
                        mem_request <= 1'b1;
                        mem_address <= {instr_addr[31:LINE_LSB], {LINE_LSB{1'b0}}};
                        state       <= FILL;
                    end
                end
                FILL: begin
                    if (flush) flush_seen <= 1'b1;
                    if (fill_ack) begin
                        fill_cnt    <= fill_next;
                        mem_address <= {miss_addr[31:LINE_LSB], fill_next, 2'b00};
                        if (fill_last) begin
                            // A flush anywhere in the fill leaves the line invalid.
                            if (!flush_seen && !flush) valid_q[miss_idx] <= 1'b1;
                            mem_request <= 1'b0;
                            state       <= RESUME;
                        end
                    end
                end
                RESUME: begin
                    instr_data <= data_mem[rd_ptr];
                    instr_ack  <= 1'b1;
                    state      <= IDLE;
                end
                default: state <= IDLE;
            endcase
            if (flush) valid_q <= '0;
        end
    end
endmodule
